// File: rtl/adc_spi_pkg.sv
// -----------------------------------------------------------------------------
// adc_spi_pkg
//   Shared definitions for the multi-channel SPI ADC receiver:
//   - state_t       : receiver FSM encoding (IDLE, SETUP, SHIFT, QUIET)
//   - DEF_*         : default parameter values used by adc_spi_rx
//   - max2()        : helper for sizing counters at elaboration time
// -----------------------------------------------------------------------------
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_BITS  = 12;
  localparam int DEF_CHANNELS   = 1;
  localparam int DEF_CLK_DIV    = 10;
  localparam int DEF_CS_IDLE    = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// -----------------------------------------------------------------------------
// adc_sclk_gen
//   Serial clock generator for adc_spi_rx.
//   Ports:
//     Clk_P      in  system clock
//     Rst_P      in  synchronous active-high reset
//     run        in  divider runs while high, held at 0 otherwise
//     toggle_en  in  allow sclk_1 to toggle at the end of the current half-period
//     sclk_1     out serial clock, idles high (registered)
//     tick       out last Clk_P cycle of a half-period
//     rise_stb   out one-cycle strobe on the Clk_P edge where sclk_1 goes 0->1
// -----------------------------------------------------------------------------
module adc_sclk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic Clk_P,
  input  logic Rst_P,
  input  logic run,
  input  logic toggle_en,
  output logic sclk_1,
  output logic tick,
  output logic rise_stb
);

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick     = run && (div_cnt == DIV_LAST);
  // sclk_1 is still low here and becomes high on this very edge.
  assign rise_stb = tick && toggle_en && !sclk_1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clk_P) begin
    if (Rst_P) begin
      div_cnt <= '0;
      sclk_1  <= 1'b1;
    end else begin
      if (!run || tick) div_cnt <= '0;
      else              div_cnt <= div_cnt + 1'b1;

      if (tick && toggle_en) sclk_1 <= ~sclk_1;
    end
  end

endmodule

// File: rtl/adc_spi_rx.sv
// -----------------------------------------------------------------------------
// adc_spi_rx
//   Multi-channel SPI ADC receiver. Drives a shared cs_1/sclk_1 pair, shifts in
//   one MSB-first frame per channel, and presents right-aligned results through
//   a valid/ready handshake. Single-shot (start) or back-to-back (continuous).
//   Optional feature macro: ADC_SPI_RX_LEADZERO_CHECK_EN enables frame_err.
//   Ports:
//     Clk_P, Rst_P   system clock, synchronous active-high reset
//     start          single-shot request, honoured only in IDLE
//     continuous     keep issuing frames while high
//     DataIn         serial data, bit k = channel k
//     cs_1, sclk_1   ADC chip select (active low) and serial clock (idle high)
//     sample         results, channel k at [k*DATA_BITS +: DATA_BITS]
//     sample_valid   sample holds an unconsumed result
//     sample_ready   consumer accept
//     busy           FSM not in IDLE
//     overrun        sticky: result overwritten before acceptance
//     frame_err      nonzero leading bits in last loaded frame (macro only)
// -----------------------------------------------------------------------------
module adc_spi_rx
  import adc_spi_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_IDLE    = DEF_CS_IDLE
) (
  input  logic                          Clk_P,
  input  logic                          Rst_P,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [CHANNELS-1:0]           DataIn,
  output logic                          cs_1,
  output logic                          sclk_1,
  output logic [CHANNELS*DATA_BITS-1:0] sample,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          busy,
  output logic                          overrun,
  output logic                          frame_err
);

  // half_cnt counts sclk half-periods inside SHIFT and QUIET.
  localparam int               CNT_W      = $clog2(max2(2 * FRAME_BITS, 2 * CS_IDLE));
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(2 * CS_IDLE - 1);

  state_t                                state, state_next;
  logic [CNT_W-1:0]                      half_cnt;
  logic [CHANNELS-1:0][FRAME_BITS-1:0]   shreg;
  logic                                  tick, rise_stb, toggle_en, load;

  assign busy = (state != IDLE);
  assign load = tick && (state == SHIFT) && (half_cnt == SHIFT_LAST);

  // sclk_1 falls at the end of SETUP and toggles every half-period in SHIFT,
  // except after the final high half, so it is already idle-high for QUIET.
  assign toggle_en = (state == SETUP) || ((state == SHIFT) && (half_cnt != SHIFT_LAST));

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .Clk_P     (Clk_P),
    .Rst_P     (Rst_P),
    .run       (busy),
    .toggle_en (toggle_en),
    .sclk_1    (sclk_1),
    .tick      (tick),
    .rise_stb  (rise_stb)
  );

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start || continuous)              state_next = SETUP;
      SETUP: if (tick)                             state_next = SHIFT;
      SHIFT: if (load)                             state_next = QUIET;
      QUIET: if (tick && (half_cnt == QUIET_LAST)) state_next = continuous ? SETUP : IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk_P) begin
    if (Rst_P) begin
      state    <= IDLE;
      half_cnt <= '0;
      cs_1     <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state) half_cnt <= '0;
      else if (tick)           half_cnt <= half_cnt + 1'b1;
      // Registered from next state so cs_1 falls the cycle after start.
      cs_1 <= !((state_next == SETUP) || (state_next == SHIFT));
    end
  end

  // NOTE: the shift registers are reset (not just overwritten) so a frame
  // aborted by reset can never leak partial bits into a later result.
  always_ff @(posedge Clk_P) begin
    if (Rst_P) begin
      shreg <= '0;
    end else if (rise_stb) begin
      for (int k = 0; k < CHANNELS; k++)
        shreg[k] <= {shreg[k][FRAME_BITS-2:0], DataIn[k]};
    end
  end

  always_ff @(posedge Clk_P) begin
    if (Rst_P) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      for (int k = 0; k < CHANNELS; k++)
        sample[k*DATA_BITS +: DATA_BITS] <= shreg[k][DATA_BITS-1:0];
      sample_valid <= 1'b1;
      // A simultaneous acceptance consumes the old result, so no overrun.
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

`ifdef ADC_SPI_RX_LEADZERO_CHECK_EN
  logic lead_bad;

  always_comb begin
    lead_bad = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      for (int b = DATA_BITS; b < FRAME_BITS; b++)
        lead_bad = lead_bad | shreg[k][b];
  end

  always_ff @(posedge Clk_P) begin
    if (Rst_P)     frame_err <= 1'b0;
    else if (load) frame_err <= lead_bad;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_rx
//   Two-channel bench for adc_spi_rx with default timing parameters. An ADC
//   model serves queued frames on DataIn; each frame's expected result is
//   pushed to a scoreboard when cs_1 falls and compared when cs_1 rises.
// -----------------------------------------------------------------------------
module tb_adc_spi_rx;

  localparam int CH = 2;
  localparam int DB = 12;
  localparam int FB = 16;

  typedef logic [CH-1:0][FB-1:0] frame_t;
  typedef struct packed {
    logic [CH*DB-1:0] sample;
    logic             ferr;
  } exp_t;

  logic              Clk_P = 1'b0;
  logic              Rst_P, start, continuous, sample_ready;
  logic [CH-1:0]     DataIn = '0;
  logic              cs_1, sclk_1, sample_valid, busy, overrun, frame_err;
  logic [CH*DB-1:0]  sample;

  always #5 Clk_P = ~Clk_P;

  adc_spi_rx #(.CHANNELS(CH)) dut (
    .Clk_P        (Clk_P),
    .Rst_P        (Rst_P),
    .start        (start),
    .continuous   (continuous),
    .DataIn       (DataIn),
    .cs_1         (cs_1),
    .sclk_1       (sclk_1),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  int     n_chk = 0;
  int     n_err = 0;
  frame_t tx_q[$];
  exp_t   exp_q[$];
  frame_t tx_cur = '0;
  int     cyc = 0, fall_cyc = 0, prev_fall_cyc = 0, n_falls = 0, load_cnt = 0, rise_cnt = 0;
  logic   prev_cs = 1'b1, prev_sclk = 1'b1, mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] w0, input logic [15:0] w1);
    frame_t f;
    f[0] = w0;
    f[1] = w1;
    return f;
  endfunction

  function automatic exp_t make_exp(input frame_t f);
    exp_t e;
    e.ferr = 1'b0;
    for (int k = 0; k < CH; k++) begin
      e.sample[k*DB +: DB] = f[k][DB-1:0];
`ifdef ADC_SPI_RX_LEADZERO_CHECK_EN
      if (f[k][FB-1:DB] != '0) e.ferr = 1'b1;
`endif
    end
    return e;
  endfunction

  // ADC model + monitor, evaluated half a cycle away from the active edge.
  always @(negedge Clk_P) begin
    exp_t e;
    cyc++;
    if (prev_cs && !cs_1) begin
      prev_fall_cyc = fall_cyc;
      fall_cyc      = cyc;
      n_falls++;
      tx_cur   = (tx_q.size() != 0) ? tx_q.pop_front() : '0;
      rise_cnt = 0;
      exp_q.push_back(make_exp(tx_cur));
    end
    if (!prev_sclk && sclk_1) rise_cnt++;
    if (!prev_cs && cs_1 && mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sample", 32'(sample), 32'(e.sample));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
      end
      check("valid_at_load", 32'(sample_valid), 32'd1);
      check("load_latency", 32'(cyc - fall_cyc), 32'd330);
      check("sclk_rises", 32'(rise_cnt), 32'd16);
      load_cnt++;
    end
    for (int k = 0; k < CH; k++)
      DataIn[k] = (rise_cnt < FB) ? tx_cur[k][FB-1-rise_cnt] : 1'b0;
    prev_cs   = cs_1;
    prev_sclk = sclk_1;
  end

  task automatic pulse_start();
    @(negedge Clk_P) start = 1'b1;
    @(negedge Clk_P) start = 1'b0;
  endtask

  task automatic wait_loads(input int n, input int budget);
    int target;
    target = load_cnt + n;
    for (int i = 0; i < budget && load_cnt < target; i++) @(negedge Clk_P);
    if (load_cnt < target) check("load_timeout", 32'(load_cnt), 32'(target));
    @(negedge Clk_P);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge Clk_P);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int falls_before;
    Rst_P = 1'b1; start = 1'b0; continuous = 1'b0; sample_ready = 1'b0;
    repeat (3) @(negedge Clk_P);
    check("rst_cs", 32'(cs_1), 32'd1);
    check("rst_sclk", 32'(sclk_1), 32'd1);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    Rst_P = 1'b0;

    // Single shot, result held until accepted.
    tx_q.push_back(mk(16'b0000_1010_1100_0011, 16'h0555));
    pulse_start();
    check("cs_fall_after_start", 32'(cs_1), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_loads(1, 1000);
    wait_idle(200);
    check("idle_cs", 32'(cs_1), 32'd1);
    check("idle_sclk", 32'(sclk_1), 32'd1);
    check("held_valid", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    @(negedge Clk_P);
    check("accept_clears_valid", 32'(sample_valid), 32'd0);
    check("no_overrun", 32'(overrun), 32'd0);

    // Continuous, consumer always ready; continuous dropped mid-SHIFT.
    tx_q.push_back(mk(16'h0123, 16'h0FFF));
    tx_q.push_back(mk(16'h0000, 16'h0800));
    continuous = 1'b1;
    wait_loads(1, 1000);
    repeat (180) @(negedge Clk_P);
    check("busy_mid_frame2", 32'(busy), 32'd1);
    continuous = 1'b0;
    wait_loads(1, 1000);
    check("frame_period", 32'(fall_cyc - prev_fall_cyc), 32'd410);
    wait_idle(200);
    check("cont_idle_cs", 32'(cs_1), 32'd1);
    check("cont_consumed", 32'(sample_valid), 32'd0);
    check("cont_no_overrun", 32'(overrun), 32'd0);

    // Overrun: two loads without acceptance.
    sample_ready = 1'b0;
    tx_q.push_back(mk(16'h0111, 16'h0222));
    tx_q.push_back(mk(16'h0333, 16'h0444));
    continuous = 1'b1;
    wait_loads(1, 1000);
    check("overrun_first_load", 32'(overrun), 32'd0);
    repeat (180) @(negedge Clk_P);
    continuous = 1'b0;
    wait_loads(1, 1000);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle(200);
    sample_ready = 1'b1;
    @(negedge Clk_P);
    check("overrun_accept_valid", 32'(sample_valid), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during bit 7 of SHIFT, then a clean frame; start while busy ignored.
    tx_q.push_back(mk(16'h0F0F, 16'h0BAD));
    pulse_start();
    for (int i = 0; i < 1000 && rise_cnt != 7; i++) @(negedge Clk_P);
    check("reach_bit7", 32'(rise_cnt), 32'd7);
    mon_en = 1'b0;
    Rst_P  = 1'b1;
    @(negedge Clk_P);
    check("abort_cs", 32'(cs_1), 32'd1);
    check("abort_sclk", 32'(sclk_1), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(sample_valid), 32'd0);
    check("abort_sample", 32'(sample), 32'd0);
    check("abort_overrun", 32'(overrun), 32'd0);
    Rst_P = 1'b0;
    exp_q.delete();
    @(negedge Clk_P);
    mon_en = 1'b1;
    tx_q.push_back(mk(16'h0A5C, 16'h03C9));
    falls_before = n_falls;
    pulse_start();
    repeat (50) @(negedge Clk_P);
    pulse_start();
    wait_loads(1, 1000);
    wait_idle(200);
    repeat (20) @(negedge Clk_P);
    check("start_busy_ignored", 32'(n_falls - falls_before), 32'd1);
    check("stays_idle", 32'(busy), 32'd0);

    // Leading-zero check (expectations follow the build macro).
    tx_q.push_back(mk(16'h8ABC, 16'h0123));
    pulse_start();
    wait_loads(1, 1000);
    wait_idle(200);
    tx_q.push_back(mk(16'h0ABC, 16'h0123));
    pulse_start();
    wait_loads(1, 1000);
    wait_idle(200);
    check("clean_frame_err", 32'(frame_err), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_spi_rx.md
# adc_spi_rx

Parametrised multi-channel SPI ADC receiver for the servo controller's feedback path. Generates shared chip-select (`cs_1`) and serial clock (`sclk_1`) for up to CHANNELS converters sharing one frame, shifts in one MSB-first frame per channel, and presents the right-aligned conversion results through a valid/ready handshake. Supports single-shot and continuous conversion, and flags results the consumer did not take in time. Sits between the `DataIn` pad(s) and the PWM/position logic, generalising the previous fixed 16-bit, single-channel front end.

## Interface
- FRAME_BITS, 16, sclk periods per frame (bits shifted per channel)
- DATA_BITS, 12, result width; the low DATA_BITS of the frame; must satisfy DATA_BITS ≤ FRAME_BITS
- CHANNELS, 1, number of parallel `DataIn` lines sharing `cs_1`/`sclk_1`
- CLK_DIV, 10, `Clk_P` cycles per sclk half-period; must be ≥ 2
- CS_IDLE, 4, sclk periods `cs_1` stays high between frames
- `Clk_P`  in  1  system clock; all logic on its rising edge
- `Rst_P`  in  1  synchronous, active-high reset
- `start`  in  1  single-shot request, sampled only in IDLE
- `continuous`  in  1  back-to-back frames while high
- `DataIn`  in  CHANNELS  serial data; bit k belongs to channel k
- `cs_1`  out  1  ADC chip select, active low
- `sclk_1`  out  1  ADC serial clock; idles high
- `sample`  out  CHANNELS*DATA_BITS  results; channel k at [k*DATA_BITS +: DATA_BITS]
- `sample_valid`  out  1  `sample` holds an unconsumed result
- `sample_ready`  in  1  consumer accepts when high together with `sample_valid`
- `busy`  out  1  high in every state except IDLE
- `overrun`  out  1  sticky: a result was overwritten before acceptance
- `frame_err`  out  1  leading-zero violation (see Configuration)

## Operation
- Reset values: `cs_1`=1, `sclk_1`=1, `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0; FSM to IDLE, divider and bit counter to 0. Reset mid-frame aborts; partial shift data is discarded.
- FSM: IDLE → SETUP when `start` or `continuous`; SETUP (`cs_1` low, `sclk_1` high, CLK_DIV cycles) → SHIFT; SHIFT (FRAME_BITS sclk periods, each CLK_DIV cycles low then CLK_DIV cycles high) → QUIET; QUIET (`cs_1` high, 2*CLK_DIV*CS_IDLE cycles) → SETUP if `continuous`, else IDLE.
- `start` outside IDLE is ignored. Dropping `continuous` mid-frame completes the current frame and then goes to IDLE.
- Each channel's shift register captures `DataIn[k]` on the `Clk_P` edge where `sclk_1` goes 0→1, MSB first.
- On entry to QUIET: `sample` loads the low DATA_BITS of every shift register, and `sample_valid` is set.
- `sample_valid` clears on the cycle `sample_valid && sample_ready`. If a new load and the acceptance occur in the same cycle, the new data loads, `sample_valid` stays 1, and no overrun is raised.
- A load while `sample_valid`=1 with no acceptance that cycle overwrites `sample` and sets `overrun`. `overrun` clears only on reset.

## Timing
- Frame period: CLK_DIV*(1 + 2*FRAME_BITS + 2*CS_IDLE) cycles; with defaults, 410.
- First `cs_1` fall: the cycle after `start` is seen in IDLE.
- `sample_valid` rises in the same cycle `cs_1` rises, which is CLK_DIV*(1+2*FRAME_BITS) cycles after `cs_1` fell.
- `sclk_1` and `cs_1` are registered outputs with no combinational path from inputs.

## Configuration
- `ADC_SPI_RX_LEADZERO_CHECK_EN` defined: at load, `frame_err` is set for that result if any of the top FRAME_BITS-DATA_BITS bits of any channel is 1. It is cleared on the next clean load and on reset. The data is still loaded.
- Not defined: `frame_err` is tied to 0 and the check logic is absent.

## Structure
- Shared package `adc_spi_pkg` holds:
  - the FSM state encoding (IDLE, SETUP, SHIFT, QUIET);
  - the default parameter constants.
- One sub-module, `adc_sclk_gen`, contains:
  - the CLK_DIV half-period counter;
  - the `sclk_1` toggle;
  - the one-cycle rising-edge sample strobe.
- The top level keeps the FSM, bit counter, shift registers and handshake.

## Test plan
- Defaults, CHANNELS=1, `start` pulse, frame 16'b0000_1010_1100_0011 → `sample`=12'hAC3; `sample_valid` rises 330 cycles after `cs_1` falls; exactly 16 sclk rising edges.
- CHANNELS=2, `continuous`=1, `sample_ready`=1, frames 0x0123/0x0FFF then 0x0000/0x0800 → `sample`=24'hFFF123 then 24'h800000; frame period 410 cycles.
- `continuous`=1, `sample_ready`=0 for two frames → second load sets `overrun`=1 and `sample` holds the second frame. Then `sample_ready`=1 → `sample_valid`=0 and `overrun` stays 1.
- Assert `Rst_P` for one cycle during bit 7 of SHIFT → next cycle `cs_1`=1, `sclk_1`=1, `busy`=0, `sample_valid`=0; a following `start` yields a correct full frame.
- Drop `continuous` mid-SHIFT → that frame completes and is delivered, then IDLE with `cs_1`=1; `start` while `busy` → no extra frame.
- With `ADC_SPI_RX_LEADZERO_CHECK_EN`: frame 16'h8ABC → `sample`=12'hABC, `frame_err`=1; next frame 16'h0ABC → `frame_err`=0.
